// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame constants, default cycle counts
// and the frame builder used by the host transmitter.
package ps2_host_tx_pkg;

  localparam int unsigned PS2_DATA_BITS      = 8;
  localparam int unsigned PS2_FRAME_FALLS    = 11;
  localparam int unsigned PS2_SHREG_W        = PS2_DATA_BITS + 2;
  localparam int unsigned PS2_BITCNT_W       = 4;
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_FIN       = 3'd6
  } ps2_state_e;

  // Bits after the start bit, in shift order from the LSB upward.
  typedef struct packed {
    logic                     stop;
    logic                     parity;
    logic [PS2_DATA_BITS-1:0] data;
  } ps2_frame_t;

  function automatic ps2_frame_t ps2_frame_build(input logic [PS2_DATA_BITS-1:0] data);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic                     i_start;
  logic [PS2_DATA_BITS-1:0] i_tx_data;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;

  modport master (
    output i_start, i_tx_data,
    input  o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_tx_data,
    output o_busy, o_done, o_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus history flop for one raw PS/2 line; flags the
// cycle in which the synchronized level has just gone from 1 to 0.
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall_c
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  always_comb begin
    meta_d = i_pin;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Lines idle high, so reset the chain to 1 to avoid a spurious fall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign o_level  = sync_q;
  assign o_fall_c = hist_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits
// LSB first, odd parity, stop, then device ACK, all in the system clock domain.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ps2_host_tx_if.slave  host,
  output logic          o_sclk_oe,
  output logic          o_data_oe,
  input  logic          i_sclk,
  input  logic          i_data
);

  localparam int unsigned TCNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned TCNT_W   = (TCNT_MAX > 1) ? $clog2(TCNT_MAX) : 1;

  logic sclk_s, sclk_fall;
  logic data_s, data_fall_unused;

  ps2_line_sync u_sclk_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_pin    (i_sclk),
    .o_level  (sclk_s),
    .o_fall_c (sclk_fall)
  );

  ps2_line_sync u_data_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_pin    (i_data),
    .o_level  (data_s),
    .o_fall_c (data_fall_unused)
  );

  ps2_state_e               state_q,   state_d;
  logic [PS2_SHREG_W-1:0]   shreg_q,   shreg_d;
  logic [PS2_BITCNT_W-1:0]  bitcnt_q,  bitcnt_d;
  logic [TCNT_W-1:0]        tcnt_q,    tcnt_d;
  logic                     sclk_oe_q, sclk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     busy_q,    busy_d;
  logic                     done_q,    done_d;
  logic                     err_q,     err_d;

  logic inhibit_end_c;
  logic timeout_c;

  // Exit one cycle early so the start bit appears INHIBIT_CYCLES after the request.
  assign inhibit_end_c = (32'(tcnt_q) + 32'd2) >= INHIBIT_CYCLES;
  assign timeout_c     = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    tcnt_d    = tcnt_q;
    sclk_oe_d = sclk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sclk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (host.i_start) begin
          shreg_d   = ps2_frame_build(host.i_tx_data);
          tcnt_d    = '0;
          bitcnt_d  = '0;
          sclk_oe_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (inhibit_end_c) begin
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        sclk_oe_d = 1'b0;
        tcnt_d    = '0;
        state_d   = ST_SEND;
      end

      // Fill with 1s so the tenth fall releases data for the stop bit.
      ST_SEND: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (timeout_c) begin
          sclk_oe_d = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_FIN;
        end else if (sclk_fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[PS2_SHREG_W-1:1]};
          bitcnt_d  = bitcnt_q + PS2_BITCNT_W'(1);
          if (bitcnt_q == PS2_BITCNT_W'(PS2_FRAME_FALLS - 2)) begin
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (timeout_c) begin
          sclk_oe_d = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_FIN;
        end else if (sclk_fall) begin
          bitcnt_d = bitcnt_q + PS2_BITCNT_W'(1);
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end

      ST_WAIT_IDLE: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (timeout_c) begin
          sclk_oe_d = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_FIN;
        end else if (sclk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end

      // The done/err pulse is visible during this state; busy drops next.
      ST_FIN: begin
        sclk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        sclk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      tcnt_q    <= '0;
      sclk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      tcnt_q    <= tcnt_d;
      sclk_oe_q <= sclk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_sclk_oe   = sclk_oe_q;
  assign o_data_oe   = data_oe_q;
  assign host.o_busy = busy_q;
  assign host.o_done = done_q;
  assign host.o_err  = err_q;

endmodule
